// File: rtl/tmr_err_monitor_if.sv
// Signal bundle between the TMR error monitor and its host/status logic.
// The monitor takes the slave modport; the voter/host side takes the master modport.
interface tmr_err_monitor_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TS_W  = 16
);
    logic             err;
    logic             clr;
    logic             err_sticky;
    logic [CNT_W-1:0] err_count;
    logic             alarm;
    logic             evt_valid;
    logic             evt_ready;
    logic [TS_W-1:0]  evt_stamp;
    logic             evt_ovf;

    modport master (
        output err,
        output clr,
        output evt_ready,
        input  err_sticky,
        input  err_count,
        input  alarm,
        input  evt_valid,
        input  evt_stamp,
        input  evt_ovf
    );

    modport slave (
        input  err,
        input  clr,
        input  evt_ready,
        output err_sticky,
        output err_count,
        output alarm,
        output evt_valid,
        output evt_stamp,
        output evt_ovf
    );
endinterface

// File: rtl/tmr_err_monitor.sv
// Error-sink monitor for a TMR voter: event counting, sticky flag, windowed alarm and a
// one-deep timestamped report buffer. Define TMR_ERR_MON_STAMP_EN to enable timestamps.
module tmr_err_monitor #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned TS_W   = 16,
    parameter int unsigned WINDOW = 64,
    parameter int unsigned THRESH = 4
) (
    input logic              clk,
    input logic              rst,
    tmr_err_monitor_if.slave mon
);
    localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned EV_W  = $clog2(THRESH + 1);

    localparam logic [WIN_W-1:0] WinLast = WIN_W'(WINDOW - 1);
    localparam logic [EV_W-1:0]  EvMax   = EV_W'(THRESH);
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {StEmpty, StFull} rpt_state_e;

    logic             err_q;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             alarm_q, alarm_d;
    logic             ovf_q, ovf_d;
    logic [WIN_W-1:0] win_timer_q, win_timer_d;
    logic [EV_W-1:0]  win_events_q, win_events_d;
    rpt_state_e       state_q, state_d;
    logic             evt;
    logic             load;

    assign evt = mon.err & ~err_q;

    // clr is applied before the current cycle's event, so a coincident event still counts.
    always_comb begin
        sticky_d = (sticky_q & ~mon.clr) | mon.err;

        count_d = mon.clr ? '0 : count_q;
        if (evt && (count_d != CntMax)) begin
            count_d = count_d + CNT_W'(1);
        end

        win_timer_d = (win_timer_q == WinLast) ? '0 : win_timer_q + WIN_W'(1);

        // A window spans win_timer 0..WINDOW-1; its first cycle starts counting afresh.
        win_events_d = (mon.clr || (win_timer_q == '0)) ? '0 : win_events_q;
        if (evt && (win_events_d != EvMax)) begin
            win_events_d = win_events_d + EV_W'(1);
        end

        alarm_d = (alarm_q & ~mon.clr) | (win_events_d == EvMax);
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ovf_d   = ovf_q & ~mon.clr;
        unique case (state_q)
            StEmpty: begin
                if (evt) begin
                    load    = 1'b1;
                    state_d = StFull;
                end
            end
            StFull: begin
                if (mon.evt_ready) begin
                    if (evt) begin
                        load = 1'b1;
                    end else begin
                        state_d = StEmpty;
                    end
                end else if (evt) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q        <= 1'b0;
            sticky_q     <= 1'b0;
            count_q      <= '0;
            alarm_q      <= 1'b0;
            ovf_q        <= 1'b0;
            win_timer_q  <= '0;
            win_events_q <= '0;
            state_q      <= StEmpty;
        end else begin
            err_q        <= mon.err;
            sticky_q     <= sticky_d;
            count_q      <= count_d;
            alarm_q      <= alarm_d;
            ovf_q        <= ovf_d;
            win_timer_q  <= win_timer_d;
            win_events_q <= win_events_d;
            state_q      <= state_d;
        end
    end

`ifdef TMR_ERR_MON_STAMP_EN
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] stamp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q    <= '0;
            stamp_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (load) begin
                stamp_q <= ts_q;
            end
        end
    end

    assign mon.evt_stamp = stamp_q;
`else
    assign mon.evt_stamp = {TS_W{1'b0}};
`endif

    assign mon.err_sticky = sticky_q;
    assign mon.err_count  = count_q;
    assign mon.alarm      = alarm_q;
    assign mon.evt_valid  = (state_q == StFull);
    assign mon.evt_ovf    = ovf_q;
endmodule
